// File: rtl/lab3_sub_pkg.sv
// ---------------------------------------------------------------------------
// lab3_sub_pkg
//   Shared definitions for the nibble-serial subtract sequencer.
//   Contents:
//     NIBBLE_W      width of the time-shared subtractor slice (4 bits)
//     sub_state_e   sequencer states IDLE / RUN / DONE
//     nibble_count  number of slice passes needed for a given operand width
//     idx_width     width of the nibble index counter (never below 1)
// ---------------------------------------------------------------------------
package lab3_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // A single-nibble build would give $clog2(1)=0, so clamp the index to 1 bit.
    function automatic int idx_width(input int width);
        int n;
        n = nibble_count(width);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lab3_nibble_sub.sv
// ---------------------------------------------------------------------------
// lab3_nibble_sub
//   Combinational 4-bit subtractor with borrow, reused from the Lab 2
//   datapath. Computes {b_out, d} = {0,a} - {0,b} - b_in.
//   Ports:
//     a      in   NIBBLE_W  minuend nibble
//     b      in   NIBBLE_W  subtrahend nibble
//     b_in   in   1         borrow into this nibble
//     d      out  NIBBLE_W  difference nibble
//     b_out  out  1         borrow out of this nibble
// ---------------------------------------------------------------------------
module lab3_nibble_sub
    import lab3_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                b_in,
    output logic [NIBBLE_W-1:0] d,
    output logic                b_out
);

    logic [NIBBLE_W:0] full;

    // The extra top bit goes to 1 exactly when the nibble underflows,
    // which is the borrow to hand to the next nibble.
    assign full  = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, b_in};
    assign d     = full[NIBBLE_W-1:0];
    assign b_out = full[NIBBLE_W];

endmodule

// File: rtl/lab3_sub_sequencer.sv
// ---------------------------------------------------------------------------
// lab3_sub_sequencer
//   Computes diff = x - y - bin (mod 2^WIDTH) by running one shared 4-bit
//   subtractor slice once per clock, least-significant nibble first, with
//   the borrow kept in a register between cycles. Valid/ready handshakes on
//   the operand side and the result side.
//
//   Parameter:
//     WIDTH      operand/result width, multiple of 4 and at least 8
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      sequencer idle and able to accept operands
//     x, y       in   WIDTH  minuend / subtrahend
//     bin        in   1      borrow-in
//     out_valid  out  1      result valid, held until out_ready
//     out_ready  in   1      consumer takes the result
//     diff       out  WIDTH  difference
//     bout       out  1      borrow out of the MSB nibble
//     zero       out  1      diff == 0 (meaningful while out_valid)
//     ovf        out  1      signed overflow, only with SUB_OVF_FLAG_EN
//
//   Build option: define SUB_OVF_FLAG_EN to add the ovf port and its logic.
// ---------------------------------------------------------------------------
module lab3_sub_sequencer
    import lab3_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 NIB_CNT  = nibble_count(WIDTH);
    localparam int                 IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIB_CNT - 1);

    sub_state_e          state_q,     state_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [WIDTH-1:0]    x_q,         x_d;
    logic [WIDTH-1:0]    y_q,         y_d;
    logic                borrow_q,    borrow_d;
    logic [WIDTH-1:0]    diff_q,      diff_d;
    logic                bout_q,      bout_d;
    logic                out_valid_q, out_valid_d;
`ifdef SUB_OVF_FLAG_EN
    logic                ovf_q,       ovf_d;
    logic                msb_borrow_in;
`endif

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_d;
    logic                nib_bout;

    // The one shared slice; idx_q picks which nibble of the latched operands
    // it sees this cycle.
    assign nib_a = x_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = y_q[idx_q*NIBBLE_W +: NIBBLE_W];

    lab3_nibble_sub u_nibble_sub (
        .a     (nib_a),
        .b     (nib_b),
        .b_in  (borrow_q),
        .d     (nib_d),
        .b_out (nib_bout)
    );

`ifdef SUB_OVF_FLAG_EN
    // Sum bit identity d = x ^ y ^ borrow recovers the borrow into the MSB.
    assign msb_borrow_in = x_q[WIDTH-1] ^ y_q[WIDTH-1] ^ nib_d[NIBBLE_W-1];
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        out_valid_d = out_valid_q;
`ifdef SUB_OVF_FLAG_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d      = x;
                    y_d      = y;
                    borrow_d = bin;
                    idx_d    = '0;
                    diff_d   = '0;
                    bout_d   = 1'b0;
`ifdef SUB_OVF_FLAG_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_d;
                borrow_d = nib_bout;
                idx_d    = idx_q + IDX_W'(1);
                // The last nibble's borrow is the result borrow; the
                // result becomes visible on this same edge.
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    bout_d      = nib_bout;
                    out_valid_d = 1'b1;
`ifdef SUB_OVF_FLAG_EN
                    ovf_d       = msb_borrow_in ^ nib_bout;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // All sequencer state in one place; reset abandons any operation in
    // flight and clears the result so nothing partial is ever presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // in_ready is held low for as long as reset is applied, and is high in
    // the first cycle after release because the state is already IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = out_valid_q && (diff_q == '0);
`ifdef SUB_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_lab3_sub_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lab3_sub_sequencer
//   Directed and random operations for lab3_sub_sequencer (WIDTH=16),
//   compared against a plain-arithmetic subtraction model.
// ---------------------------------------------------------------------------
module tb_lab3_sub_sequencer;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_i;
    logic [W-1:0] y_i;
    logic         bin_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    lab3_sub_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_i),
        .y         (y_i),
        .bin       (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: unsigned W+1-bit subtraction; bit W is the final borrow.
    function automatic logic [W:0] modelSub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bi);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    endfunction

`ifdef SUB_OVF_FLAG_EN
    // Reference: true signed result falls outside the W-bit two's-complement range.
    function automatic logic modelOvf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic bi);
        longint r;
        r = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        return (r > longint'(2**(W-1) - 1)) || (r < -longint'(2**(W-1)));
    endfunction
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for in_ready, then presents operands for exactly one edge.
    // Returns #1 after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic ab);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        x_i      = ax;
        y_i      = ay;
        bin_i    = ab;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic waitResult();
        int lat;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput("out_valid_latency", 32'(lat), 32'(LAT));
    endtask

    task automatic checkResult(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic ab);
        logic [W:0] e;
        e = modelSub(ax, ay, ab);
        checkOutput($sformatf("diff x=%h y=%h b=%0d", ax, ay, ab), 32'(diff), 32'(e[W-1:0]));
        checkOutput($sformatf("bout x=%h y=%h b=%0d", ax, ay, ab), 32'(bout), 32'(e[W]));
        checkOutput($sformatf("zero x=%h y=%h b=%0d", ax, ay, ab), 32'(zero),
                    32'(e[W-1:0] == '0));
`ifdef SUB_OVF_FLAG_EN
        checkOutput($sformatf("ovf x=%h y=%h b=%0d", ax, ay, ab), 32'(ovf),
                    32'(modelOvf(ax, ay, ab)));
`endif
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_after_release", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic runOp(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic ab,
                         input int hold);
        applyStimulus(ax, ay, ab);
        waitResult();
        checkResult(ax, ay, ab);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) checkResult(ax, ay, ab);
        releaseResult();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] held_diff;
        logic         held_bout;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_i       = '0;
        y_i       = '0;
        bin_i     = 1'b0;

        // Values while reset is held.
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_bout", 32'(bout), 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd0);
`ifdef SUB_OVF_FLAG_EN
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_reset", 32'(out_valid), 32'd0);

        // Directed corner cases.
        runOp(16'hFFFF, 16'hFFFF, 1'b1, 0);
        runOp(16'h1000, 16'h0001, 1'b0, 0);
        runOp(16'h0005, 16'h0005, 1'b0, 0);
        runOp(16'h0001, 16'h000D, 1'b0, 0);
        runOp(16'h8000, 16'h0001, 1'b0, 0);
        runOp(16'h0006, 16'h0001, 1'b0, 0);
        runOp(16'h7FFF, 16'hFFFF, 1'b0, 1);

        // Backpressure: result held while new operands are waved at the input.
        applyStimulus(16'h1234, 16'h0FED, 1'b1);
        waitResult();
        checkResult(16'h1234, 16'h0FED, 1'b1);
        held_diff = diff;
        held_bout = bout;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            x_i      = W'($urandom);
            y_i      = W'($urandom);
            bin_i    = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_diff_stable", 32'(diff), 32'(held_diff));
            checkOutput("bp_bout_stable", 32'(bout), 32'(held_bout));
        end
        // out_ready together with in_valid: the operands must wait for IDLE.
        in_valid  = 1'b1;
        x_i       = 16'h4000;
        y_i       = 16'h0100;
        bin_i     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        runOp(16'h4000, 16'h0100, 1'b0, 0);

        // Reset during the second RUN cycle.
        applyStimulus(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_rst_diff", 32'(diff), 32'd0);
        checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun_after_rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_after_rel_out_valid", 32'(out_valid), 32'd0);
        runOp(16'hC000, 16'h3000, 1'b1, 0);

        // Random operations with random consumer stalls.
        for (int n = 0; n < 25; n++) begin
            runOp(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
